// File: rtl/clr_seq.sv
// clr_seq: multi-cycle rotate/shift unit.
//
// Captures an N-bit word, a W-bit amount and a 2-bit mode on an accepted
// start, then moves the word by up to STEP positions per cycle until the
// amount is consumed. Mode 0 rotates left, mode 1 rotates right, mode 2
// shifts left with zero fill, and mode 3 shifts right with zero fill.
//
// Ports:
//   clk   - clock; all state changes on the rising edge
//   rst   - synchronous active-high reset
//   start - request, sampled only while idle
//   x     - operand (N bits), captured on accept
//   y     - amount (W bits), captured on accept
//   mode  - operation select, captured on accept
//   r     - result register; final while done=1, held until the next accept
//   busy  - high while an operation is in progress or completing
//   done  - one-cycle completion strobe
module clr_seq #(
    parameter int unsigned N    = 28,
    parameter int unsigned W    = 5,
    parameter int unsigned STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [W-1:0] y,
    input  logic [1:0]   mode,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   r_q, r_d;
    logic [W-1:0]   count_q, count_d;
    logic [1:0]     mode_q, mode_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [31:0]    k;
    logic [2*N-1:0] dbl_l, dbl_r;
    logic [N-1:0]   r_step;

    // Positions moved this cycle: never more than what remains, so count
    // cannot underflow.
    always_comb begin
        if (32'(count_q) < STEP) k = 32'(count_q);
        else                     k = STEP;
    end

    // Single STEP-position stage. Rotations use a doubled word so the bits
    // leaving one end land at the other; k <= N keeps this exact.
    always_comb begin
        dbl_l = {r_q, r_q} << k;
        dbl_r = {r_q, r_q} >> k;
        case (mode_q)
            2'd0:    r_step = dbl_l[2*N-1:N];
            2'd1:    r_step = dbl_r[N-1:0];
            2'd2:    r_step = r_q << k;
            default: r_step = r_q >> k;
        endcase
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = x;
                    count_d = y;
                    mode_d  = mode;
                    state_d = (y != '0) ? S_ROT : S_DONE;
                end
            end
            S_ROT: begin
                r_d     = r_step;
                count_d = count_q - W'(k);
                if (count_q == W'(k)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Status flags are registered copies of the next-state decode.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            count_q <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_clr_seq.sv
// tb_clr_seq: self-checking bench for clr_seq with N=28, W=5.
// Two instances (STEP=1 and STEP=4) share data inputs and reset and have
// separate start strobes. Results are checked against a behavioural model
// built from plain arithmetic; latency follows ceil(y/STEP).
module tb_clr_seq;

    localparam int unsigned N = 28;
    localparam int unsigned W = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start1, start4;
    logic [N-1:0]  x;
    logic [W-1:0]  y;
    logic [1:0]    mode;
    logic [N-1:0]  r1, r4;
    logic          busy1, done1, busy4, done4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clr_seq #(.N(N), .W(W), .STEP(1)) u_step1 (
        .clk(clk), .rst(rst), .start(start1), .x(x), .y(y), .mode(mode),
        .r(r1), .busy(busy1), .done(done1)
    );

    clr_seq #(.N(N), .W(W), .STEP(4)) u_step4 (
        .clk(clk), .rst(rst), .start(start4), .x(x), .y(y), .mode(mode),
        .r(r4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: rotation by y mod N, shifts saturate to zero at y >= N.
    function automatic logic [N-1:0] ref_res(input logic [N-1:0] a, input int unsigned amt,
                                             input logic [1:0] m);
        int unsigned s;
        s = amt % N;
        case (m)
            2'd0:    return (a << s) | (a >> (N - s));
            2'd1:    return (a >> s) | (a << (N - s));
            2'd2:    return (amt >= N) ? '0 : (a << amt);
            default: return (amt >= N) ? '0 : (a >> amt);
        endcase
    endfunction

    task automatic chk_state(input int st, input string tag, input logic [N-1:0] er,
                             input logic eb, input logic ed, input logic check_r);
        if (st == 1) begin
            chk({tag, "/busy"}, 32'(busy1), 32'(eb));
            chk({tag, "/done"}, 32'(done1), 32'(ed));
            if (check_r) chk({tag, "/r"}, 32'(r1), 32'(er));
        end else begin
            chk({tag, "/busy"}, 32'(busy4), 32'(eb));
            chk({tag, "/done"}, 32'(done4), 32'(ed));
            if (check_r) chk({tag, "/r"}, 32'(r4), 32'(er));
        end
    endtask

    // One complete operation on the chosen instance, checking busy/done each
    // cycle, the result at done and the held result one cycle later.
    task automatic run_op(input int st, input logic [N-1:0] xv, input logic [W-1:0] yv,
                          input logic [1:0] mv, input logic [N-1:0] exp, input string tag);
        int lat;
        lat = (int'(yv) + st - 1) / st;
        @(negedge clk);
        x = xv; y = yv; mode = mv;
        if (st == 1) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        // Inputs are don't-care after accept; scramble them.
        x = N'($urandom); y = W'($urandom); mode = 2'($urandom);
        for (int i = 0; i < lat; i++) begin
            chk_state(st, {tag, "/rot"}, '0, 1'b1, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        chk_state(st, {tag, "/done"}, exp, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk_state(st, {tag, "/idle"}, exp, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [N-1:0] xv, a0;
        logic [W-1:0] yv;
        logic [1:0]   mv;
        a0 = 28'h55330FF;
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        x = '0; y = '0; mode = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_state(1, "reset1", '0, 1'b0, 1'b0, 1'b1);
        chk_state(4, "reset4", '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); rst = 1'b0;

        run_op(1, a0, 5'd1,  2'd0, 28'hAA661FE, "rotl1");
        run_op(1, a0, 5'd2,  2'd0, 28'h54CC3FD, "rotl2");
        run_op(1, a0, 5'd0,  2'd0, 28'h55330FF, "rotl0");
        run_op(1, a0, 5'd28, 2'd0, 28'h55330FF, "rotl28");
        run_op(1, a0, 5'd1,  2'd1, 28'hAA9987F, "rotr1");
        run_op(1, a0, 5'd4,  2'd2, 28'h5330FF0, "shl4");
        run_op(1, a0, 5'd30, 2'd3, 28'h0000000, "shr30");
        run_op(1, 28'hFFFFFFF, 5'd27, 2'd2, 28'h8000000, "shl27");
        run_op(4, a0, 5'd2,  2'd0, 28'h54CC3FD, "s4_rotl2");
        run_op(4, a0, 5'd9,  2'd0, ref_res(a0, 9, 2'd0), "s4_rotl9");
        run_op(4, a0, 5'd31, 2'd1, ref_res(a0, 31, 2'd1), "s4_rotr31");
        run_op(4, 28'hFFFFFFF, 5'd28, 2'd3, 28'h0, "s4_shr28");

        // Reset mid-operation discards the partial result.
        @(negedge clk);
        x = a0; y = 5'd20; mode = 2'd0; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_state(1, "midrst", '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); rst = 1'b0;

        // start held through an operation: ignored in ROT/DONE, accepted again in IDLE.
        @(negedge clk);
        x = a0; y = 5'd3; mode = 2'd0; start1 = 1'b1;
        @(posedge clk); #1;
        x = 28'h1234567; y = 5'd1; mode = 2'd1;
        chk_state(1, "hold_t0", '0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_state(1, "hold_t2", '0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_state(1, "hold_done", ref_res(a0, 3, 2'd0), 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk_state(1, "hold_idle", ref_res(a0, 3, 2'd0), 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start1 = 1'b0;
        chk_state(1, "hold_reacc", '0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_state(1, "hold_done2", ref_res(28'h1234567, 1, 2'd1), 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            xv = N'($urandom); yv = W'($urandom); mv = 2'($urandom);
            run_op(1, xv, yv, mv, ref_res(xv, int'(yv), mv), $sformatf("rnd1_%0d", i));
            xv = N'($urandom); yv = W'($urandom); mv = 2'($urandom);
            run_op(4, xv, yv, mv, ref_res(xv, int'(yv), mv), $sformatf("rnd4_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
